asteroid_spawner: RTL and testbench
===================================

Name: asteroid_spawner

Overview:
Consumer of the free-running 1..500 counter value. Uses that value as a cheap random source to place and pace asteroid spawns.
Counts display frames between spawns and samples the counter when the interval expires. Issues a held spawn request (x position, speed) to the asteroid object logic, with a request/acknowledge handshake.
Shortens the spawn interval as the game progresses. Sits between the frame-timing/counter logic and the asteroid object pool.

Parameters:
SPAWN_INTERVAL, 60, initial frames between spawns (1..127)
MIN_INTERVAL, 15, floor for the interval (1..SPAWN_INTERVAL)
STEP, 5, interval reduction per difficulty step
SPAWNS_PER_STEP, 8, acknowledged spawns per difficulty step
X_OFFSET, 70, added to the sampled value to form spawn_x
RAND_MAX, 500, largest legal rand_val

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-high
enable  in  1  game running; spawning allowed
frame_tick  in  1  one-cycle pulse per display frame
rand_val  in  10  free-running counter value, nominally 1..RAND_MAX
spawn_ack  in  1  asteroid pool accepted the request
spawn_req  out  1  spawn request, held until acknowledged
spawn_x  out  10  spawn x coordinate
spawn_speed  out  3  spawn vertical speed, 1..4
spawn_count  out  8  acknowledged spawns, saturating at 255
interval  out  7  current frames-between-spawns

Behaviour:
- Reset (async, any state): state IDLE, spawn_req=0, spawn_x=0, spawn_speed=0, spawn_count=0, interval=SPAWN_INTERVAL, frame counter=0. All outputs registered.
- IDLE: enable=1 -> WAIT; frame counter loaded with interval.
- WAIT:
  - frame_tick with frame counter>1 -> decrement.
  - frame_tick with frame counter==1 -> SAMPLE.
  - enable=0 -> IDLE, frame counter cleared. enable has priority over a simultaneous tick.
- SAMPLE (exactly one cycle):
  - sanitize r = 250 if rand_val==0 or rand_val>RAND_MAX, else rand_val.
  - spawn_x <= r + X_OFFSET (10-bit, no overflow for defaults).
  - spawn_speed <= {1'b0, r[1:0]} + 1.
  - -> REQ; spawn_req <= 1.
- Latency: expiring tick in cycle t -> SAMPLE in t+1 -> spawn_req=1 in t+2.
- REQ:
  - spawn_req, spawn_x and spawn_speed are held stable until spawn_ack=1 is sampled.
  - frame_tick is ignored in SAMPLE and REQ. Rand_val changes have no effect.
- On ack in REQ:
  - spawn_req <= 0 next cycle.
  - spawn_count <= min(spawn_count+1, 255).
  - If the new spawn_count is a multiple of SPAWNS_PER_STEP (and not saturated): interval <= max(interval-STEP, MIN_INTERVAL).
  - Next state: WAIT with frame counter = the updated interval if enable=1, otherwise IDLE.
- An ack arriving in the same cycle spawn_req first reads 1 is accepted.
- spawn_ack outside REQ is ignored.
- enable=0 during SAMPLE/REQ: the request still completes (waits for ack); exit to IDLE afterwards.
- spawn_count and interval persist across enable toggles. Only reset restores them.
- Interval arithmetic uses a signed/wider compare so interval-STEP never wraps below MIN_INTERVAL.

Decomposition:
- Shared package asteroid_pkg:
  - state enum IDLE/WAIT/SAMPLE/REQ
  - RAND_DEFAULT=250
  - screen width constants
  - widths for x (10) and speed (3)
- One natural sub-module: frame_interval_timer. It is a loadable 7-bit down-counter advanced by frame_tick. It has load, clear and expire outputs and uses the same clk/reset.

Test Plan:
1. Reset asserted mid-REQ with spawn_x=170 -> all outputs 0 immediately (async), interval=60, spawn_count=0; no req after reset release with enable=0.
2. enable=1, rand_val=100, 60 frame_ticks -> spawn_req high 2 cycles after 60th tick, spawn_x=170, spawn_speed=1; ack -> req low next cycle, spawn_count=1.
3. rand_val=0 at SAMPLE, then repeat with rand_val=501 -> spawn_x=320, spawn_speed=3 in both cases.
4. Withhold ack 20 cycles while rand_val and frame_tick toggle -> spawn_req, spawn_x, spawn_speed unchanged; ack -> full 60-tick wait before next request.
5. Immediate ack each spawn -> interval=55 after 8th ack, 50 after 16th, 15 after 72nd, still 15 after 80th.
6. Drop enable after 30 ticks in WAIT -> IDLE, no request; re-enable -> request only after a further full interval of ticks.

Source files
------------

// File: rtl/asteroid_pkg.sv
// Shared types and constants for the asteroid spawn path: FSM states, field
// widths and the fallback random value used when the counter reads out of range.
package asteroid_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        REQ    = 2'd3
    } state_t;

    localparam int RAND_DEFAULT = 250;
    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;

    localparam int RAND_W     = 10;
    localparam int X_W        = 10;
    localparam int SPEED_W    = 3;
    localparam int INTERVAL_W = 7;
    localparam int COUNT_W    = 8;

endpackage

// File: rtl/frame_interval_timer.sv
// Loadable frame down-counter: counts frame_tick pulses while run is high and
// flags expiry on the tick that would take the count below one.
module frame_interval_timer
    import asteroid_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  tick,
    input  logic                  load,
    input  logic                  clear,
    input  logic [INTERVAL_W-1:0] load_val,
    output logic                  expire
);

    logic [INTERVAL_W-1:0] cnt_q;
    logic [INTERVAL_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (run && tick && (cnt_q > INTERVAL_W'(1))) begin
            cnt_d = cnt_q - INTERVAL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = run && tick && (cnt_q == INTERVAL_W'(1));

endmodule

// File: rtl/asteroid_spawner.sv
// Paces asteroid spawns from frame ticks, samples the free-running counter as a
// cheap random x/speed source, and hands requests to the object pool.
module asteroid_spawner
    import asteroid_pkg::*;
#(
    parameter int SPAWN_INTERVAL  = 60,
    parameter int MIN_INTERVAL    = 15,
    parameter int STEP            = 5,
    parameter int SPAWNS_PER_STEP = 8,
    parameter int X_OFFSET        = 70,
    parameter int RAND_MAX        = 500
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  frame_tick,
    input  logic [RAND_W-1:0]     rand_val,
    input  logic                  spawn_ack,
    output logic                  spawn_req,
    output logic [X_W-1:0]        spawn_x,
    output logic [SPEED_W-1:0]    spawn_speed,
    output logic [COUNT_W-1:0]    spawn_count,
    output logic [INTERVAL_W-1:0] interval
);

    function automatic logic [RAND_W-1:0] sanitize(input logic [RAND_W-1:0] v);
        if ((v == '0) || (int'(v) > RAND_MAX)) begin
            return RAND_W'(RAND_DEFAULT);
        end
        return v;
    endfunction

    // Wider signed subtract so a small interval can never wrap past the floor.
    function automatic logic [INTERVAL_W-1:0] step_down(input logic [INTERVAL_W-1:0] cur);
        logic signed [INTERVAL_W+1:0] diff;
        logic signed [INTERVAL_W+1:0] floor_s;
        diff    = $signed({2'b00, cur}) - $signed((INTERVAL_W+2)'(STEP));
        floor_s = $signed((INTERVAL_W+2)'(MIN_INTERVAL));
        if (diff < floor_s) begin
            return INTERVAL_W'(MIN_INTERVAL);
        end
        return diff[INTERVAL_W-1:0];
    endfunction

    state_t                state_q, state_d;
    logic                  req_q, req_d;
    logic [X_W-1:0]        x_q, x_d;
    logic [SPEED_W-1:0]    speed_q, speed_d;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic [INTERVAL_W-1:0] interval_q, interval_d;

    logic                  tmr_load;
    logic                  tmr_clear;
    logic                  tmr_run;
    logic                  tmr_expire;
    logic [RAND_W-1:0]     rand_s;
    logic [COUNT_W-1:0]    count_inc;
    logic                  step_hit;

    assign rand_s    = sanitize(rand_val);
    assign count_inc = (count_q == '1) ? count_q : count_q + COUNT_W'(1);
    assign step_hit  = (count_q != '1) && ((int'(count_inc) % SPAWNS_PER_STEP) == 0);
    assign tmr_run   = (state_q == WAIT) && enable;

    frame_interval_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .run      (tmr_run),
        .tick     (frame_tick),
        .load     (tmr_load),
        .clear    (tmr_clear),
        .load_val (interval_d),
        .expire   (tmr_expire)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        x_d        = x_q;
        speed_d    = speed_q;
        count_d    = count_q;
        interval_d = interval_q;
        tmr_load   = 1'b0;
        tmr_clear  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d  = WAIT;
                    tmr_load = 1'b1;
                end
            end
            WAIT: begin
                if (!enable) begin
                    state_d   = IDLE;
                    tmr_clear = 1'b1;
                end else if (tmr_expire) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                x_d     = rand_s + X_W'(X_OFFSET);
                speed_d = {1'b0, rand_s[1:0]} + SPEED_W'(1);
                req_d   = 1'b1;
                state_d = REQ;
            end
            REQ: begin
                // The new interval feeds the timer load in the same cycle.
                if (spawn_ack) begin
                    req_d   = 1'b0;
                    count_d = count_inc;
                    if (step_hit) begin
                        interval_d = step_down(interval_q);
                    end
                    if (enable) begin
                        state_d  = WAIT;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            x_q        <= '0;
            speed_q    <= '0;
            count_q    <= '0;
            interval_q <= INTERVAL_W'(SPAWN_INTERVAL);
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            x_q        <= x_d;
            speed_q    <= speed_d;
            count_q    <= count_d;
            interval_q <= interval_d;
        end
    end

    assign spawn_req   = req_q;
    assign spawn_x     = x_q;
    assign spawn_speed = speed_q;
    assign spawn_count = count_q;
    assign interval    = interval_q;

endmodule

// File: tb/tb_asteroid_spawner.sv
// Directed bench for asteroid_spawner: reset, sampling, sanitising, request
// holding, enable handling and interval shortening with count saturation.
module tb_asteroid_spawner;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       frame_tick;
    logic [9:0] rand_val;
    logic       spawn_ack;
    logic       spawn_req;
    logic [9:0] spawn_x;
    logic [2:0] spawn_speed;
    logic [7:0] spawn_count;
    logic [6:0] interval;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    asteroid_spawner dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .frame_tick  (frame_tick),
        .rand_val    (rand_val),
        .spawn_ack   (spawn_ack),
        .spawn_req   (spawn_req),
        .spawn_x     (spawn_x),
        .spawn_speed (spawn_speed),
        .spawn_count (spawn_count),
        .interval    (interval)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cyc(1);
            frame_tick = 1'b0;
            cyc(1);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b0; frame_tick = 1'b0; spawn_ack = 1'b0; rand_val = 10'd0;
        cyc(2);
        total++; if (spawn_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %0d want 0", spawn_req); end
        total++; if (spawn_x !== 10'd0) begin bad++; $display("FAIL rst_x: got %0d want 0", spawn_x); end
        total++; if (spawn_speed !== 3'd0) begin bad++; $display("FAIL rst_speed: got %0d want 0", spawn_speed); end
        total++; if (spawn_count !== 8'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", spawn_count); end
        total++; if (interval !== 7'd60) begin bad++; $display("FAIL rst_interval: got %0d want 60", interval); end
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic test_basic;
        rand_val = 10'd100;
        enable = 1'b1;
        cyc(1);
        pulse_ticks(59);
        total++; if (spawn_req !== 1'b0) begin bad++; $display("FAIL basic_early: req=%0d want 0", spawn_req); end
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        total++; if (spawn_req !== 1'b0) begin bad++; $display("FAIL basic_sample_cycle: req=%0d want 0", spawn_req); end
        cyc(1);
        total++; if (spawn_req !== 1'b1) begin bad++; $display("FAIL basic_req: req=%0d want 1", spawn_req); end
        total++; if (spawn_x !== 10'd170) begin bad++; $display("FAIL basic_x: got %0d want 170", spawn_x); end
        total++; if (spawn_speed !== 3'd1) begin bad++; $display("FAIL basic_speed: got %0d want 1", spawn_speed); end
        spawn_ack = 1'b1;
        cyc(1);
        spawn_ack = 1'b0;
        total++; if (spawn_req !== 1'b0) begin bad++; $display("FAIL basic_ack_req: req=%0d want 0", spawn_req); end
        total++; if (spawn_count !== 8'd1) begin bad++; $display("FAIL basic_count: got %0d want 1", spawn_count); end
    endtask

    task automatic test_sanitize;
        logic [9:0] vals [2];
        vals[0] = 10'd0;
        vals[1] = 10'd501;
        for (int i = 0; i < 2; i++) begin
            rand_val = vals[i];
            pulse_ticks(60);
            total++; if (spawn_req !== 1'b1) begin bad++; $display("FAIL san_req[%0d]: req=%0d want 1", i, spawn_req); end
            total++; if (spawn_x !== 10'd320) begin bad++; $display("FAIL san_x[%0d]: got %0d want 320", i, spawn_x); end
            total++; if (spawn_speed !== 3'd3) begin bad++; $display("FAIL san_speed[%0d]: got %0d want 3", i, spawn_speed); end
            spawn_ack = 1'b1;
            cyc(1);
            spawn_ack = 1'b0;
            total++; if (spawn_req !== 1'b0) begin bad++; $display("FAIL san_ack[%0d]: req=%0d want 0", i, spawn_req); end
        end
        total++; if (spawn_count !== 8'd3) begin bad++; $display("FAIL san_count: got %0d want 3", spawn_count); end
    endtask

    task automatic test_hold;
        rand_val = 10'd100;
        pulse_ticks(60);
        total++; if (spawn_req !== 1'b1) begin bad++; $display("FAIL hold_start: req=%0d want 1", spawn_req); end
        for (int i = 0; i < 20; i++) begin
            rand_val   = 10'((i * 37 + 3) % 1024);
            frame_tick = (i % 2 == 0);
            cyc(1);
            total++;
            if (spawn_req !== 1'b1 || spawn_x !== 10'd170 || spawn_speed !== 3'd1) begin
                bad++;
                $display("FAIL hold_stable[%0d]: req=%0d x=%0d speed=%0d want 1/170/1", i, spawn_req, spawn_x, spawn_speed);
            end
        end
        frame_tick = 1'b0;
        rand_val   = 10'd100;
        spawn_ack  = 1'b1;
        cyc(1);
        spawn_ack  = 1'b0;
        total++; if (spawn_req !== 1'b0) begin bad++; $display("FAIL hold_ack: req=%0d want 0", spawn_req); end
        total++; if (spawn_count !== 8'd4) begin bad++; $display("FAIL hold_count: got %0d want 4", spawn_count); end
        pulse_ticks(59);
        total++; if (spawn_req !== 1'b0) begin bad++; $display("FAIL hold_rewait: req=%0d want 0", spawn_req); end
        pulse_ticks(1);
        total++; if (spawn_req !== 1'b1) begin bad++; $display("FAIL hold_next_req: req=%0d want 1", spawn_req); end
        spawn_ack = 1'b1;
        cyc(1);
        spawn_ack = 1'b0;
        total++; if (spawn_count !== 8'd5) begin bad++; $display("FAIL hold_count2: got %0d want 5", spawn_count); end
    endtask

    task automatic test_reset_mid_req;
        rand_val = 10'd100;
        pulse_ticks(60);
        total++; if (spawn_x !== 10'd170 || spawn_req !== 1'b1) begin bad++; $display("FAIL mid_pre: req=%0d x=%0d want 1/170", spawn_req, spawn_x); end
        #3;
        reset = 1'b1;
        #1;
        total++; if (spawn_req !== 1'b0) begin bad++; $display("FAIL mid_req: got %0d want 0", spawn_req); end
        total++; if (spawn_x !== 10'd0) begin bad++; $display("FAIL mid_x: got %0d want 0", spawn_x); end
        total++; if (spawn_speed !== 3'd0) begin bad++; $display("FAIL mid_speed: got %0d want 0", spawn_speed); end
        total++; if (spawn_count !== 8'd0) begin bad++; $display("FAIL mid_count: got %0d want 0", spawn_count); end
        total++; if (interval !== 7'd60) begin bad++; $display("FAIL mid_interval: got %0d want 60", interval); end
        enable = 1'b0;
        cyc(1);
        reset = 1'b0;
        pulse_ticks(70);
        total++; if (spawn_req !== 1'b0) begin bad++; $display("FAIL mid_noreq: req=%0d want 0", spawn_req); end
    endtask

    task automatic test_enable_drop;
        rand_val = 10'd100;
        enable = 1'b1;
        cyc(1);
        pulse_ticks(30);
        enable = 1'b0;
        cyc(1);
        pulse_ticks(80);
        total++; if (spawn_req !== 1'b0) begin bad++; $display("FAIL en_idle: req=%0d want 0", spawn_req); end
        enable = 1'b1;
        cyc(1);
        pulse_ticks(59);
        total++; if (spawn_req !== 1'b0) begin bad++; $display("FAIL en_full_wait: req=%0d want 0", spawn_req); end
        pulse_ticks(1);
        total++; if (spawn_req !== 1'b1) begin bad++; $display("FAIL en_req: req=%0d want 1", spawn_req); end
        enable = 1'b0;
        cyc(3);
        total++; if (spawn_req !== 1'b1) begin bad++; $display("FAIL en_req_held: req=%0d want 1", spawn_req); end
        spawn_ack = 1'b1;
        cyc(1);
        spawn_ack = 1'b0;
        total++; if (spawn_req !== 1'b0) begin bad++; $display("FAIL en_ack: req=%0d want 0", spawn_req); end
        total++; if (spawn_count !== 8'd1) begin bad++; $display("FAIL en_count: got %0d want 1", spawn_count); end
        pulse_ticks(70);
        total++; if (spawn_req !== 1'b0) begin bad++; $display("FAIL en_after_idle: req=%0d want 0", spawn_req); end
    endtask

    task automatic test_difficulty;
        int exp_before;
        int exp_after;
        int exp_count;
        int w;
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        rand_val = 10'd100;
        enable = 1'b1;
        cyc(1);
        exp_before = 60;
        for (int k = 1; k <= 257; k++) begin
            pulse_ticks(exp_before - 1);
            total++; if (spawn_req !== 1'b0) begin bad++; $display("FAIL diff_early[%0d]: req=%0d want 0", k, spawn_req); end
            frame_tick = 1'b1;
            cyc(1);
            frame_tick = 1'b0;
            w = 0;
            while (spawn_req !== 1'b1 && w < 4) begin
                cyc(1);
                w++;
            end
            total++; if (w != 1) begin bad++; $display("FAIL diff_latency[%0d]: cycles=%0d want 1", k, w); end
            spawn_ack = 1'b1;
            cyc(1);
            spawn_ack = 1'b0;
            exp_count = (k > 255) ? 255 : k;
            exp_after = 60 - 5 * (exp_count / 8);
            if (exp_after < 15) exp_after = 15;
            total++; if (spawn_count !== 8'(exp_count)) begin bad++; $display("FAIL diff_count[%0d]: got %0d want %0d", k, spawn_count, exp_count); end
            total++; if (interval !== 7'(exp_after)) begin bad++; $display("FAIL diff_interval[%0d]: got %0d want %0d", k, interval, exp_after); end
            exp_before = exp_after;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sanitize();
        test_hold();
        test_reset_mid_req();
        test_enable_drop();
        test_difficulty();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
